// File: rtl/spi_byte_slave_pkg.sv
// Shared types and constants for the SPI byte slave front end.
package spi_byte_slave_pkg;

  localparam int BYTE_WIDTH_DEF  = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Synchroniser lane assignment and per-lane reset values (NSS idles high).
  localparam int SIG_NSS  = 0;
  localparam int SIG_SCK  = 1;
  localparam int SIG_MOSI = 2;
  localparam int NUM_SIGS = 3;
  localparam logic [NUM_SIGS-1:0] SYNC_RST_VALS = 3'b001;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous pin with a configurable reset level.
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ff <= {SYNC_STAGES{RST_VAL}};
    else          ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte slave: pin resync, byte deserialise/serialise, frame markers.
// Define SPI_MSB_FIRST_EN for MSB-first shifting; LSB-first otherwise.
module spi_byte_slave
  import spi_byte_slave_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_nss,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [BYTE_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_first,
  input  logic [BYTE_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  output logic                  frame_active,
  output logic                  frame_end
);

`ifdef SPI_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  localparam int               CNT_W    = (BYTE_WIDTH > 2) ? $clog2(BYTE_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_WIDTH - 1);
  localparam logic [CNT_W-1:0] LEAD_POS = MSB_FIRST ? LAST_BIT : '0;

  logic [NUM_SIGS-1:0] pins, synced;
  assign pins = {spi_mosi, spi_sck, spi_nss};

  for (genvar g = 0; g < NUM_SIGS; g++) begin : g_sync
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST_VALS[g])) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pins[g]),
      .q       (synced[g])
    );
  end

  // vld_pipe masks edges until the chains hold real pin samples, so an NSS
  // held low through reset does not look like a fresh frame start.
  logic [SYNC_STAGES:0] vld_pipe;
  logic nss_q, sck_q, mosi_d;
  logic nss_fall, nss_rise, sck_rise, sck_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      nss_q    <= 1'b1;
      sck_q    <= 1'b0;
      mosi_d   <= 1'b0;
      nss_fall <= 1'b0;
      nss_rise <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      nss_q    <= synced[SIG_NSS];
      sck_q    <= synced[SIG_SCK];
      mosi_d   <= synced[SIG_MOSI];
      nss_fall <= vld_pipe[SYNC_STAGES] &  nss_q & ~synced[SIG_NSS];
      nss_rise <= vld_pipe[SYNC_STAGES] & ~nss_q &  synced[SIG_NSS];
      sck_rise <= vld_pipe[SYNC_STAGES] & ~sck_q &  synced[SIG_SCK];
      sck_fall <= vld_pipe[SYNC_STAGES] &  sck_q & ~synced[SIG_SCK];
    end
  end

  spi_state_e state, state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (nss_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (nss_rise) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  logic [CNT_W-1:0]      bit_cnt, pos;
  logic                  first_flag, miso_q;
  logic [BYTE_WIDTH-1:0] rx_sh, tx_sh, rx_next;

  // bit_cnt counts bits already transferred, so it also indexes the next bit.
  assign pos = MSB_FIRST ? (LAST_BIT - bit_cnt) : bit_cnt;

  always_comb begin
    rx_next      = rx_sh;
    rx_next[pos] = mosi_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      first_flag <= 1'b0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      tx_load    <= 1'b0;
      frame_end  <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      tx_load   <= 1'b0;
      frame_end <= 1'b0;
      if (state == ST_IDLE) begin
        if (nss_fall) begin
          first_flag <= 1'b1;
          tx_load    <= 1'b1;
          bit_cnt    <= '0;
          if (sck_rise) begin
            rx_sh   <= rx_next;
            bit_cnt <= CNT_W'(1);
          end
        end
      end else if (nss_rise) begin
        bit_cnt   <= '0;
        frame_end <= 1'b1;
        miso_q    <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_sh <= rx_next;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt    <= '0;
            rx_data    <= rx_next;
            rx_valid   <= 1'b1;
            rx_first   <= first_flag;
            first_flag <= 1'b0;
            tx_load    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        if (sck_fall && bit_cnt != '0) miso_q <= tx_sh[pos];
        // tx_data is captured at the end of the tx_load cycle so it may be
        // derived combinationally from the rx_data published in that cycle.
        if (tx_load) begin
          tx_sh  <= tx_data;
          miso_q <= tx_data[LEAD_POS];
        end
      end
    end
  end

  assign frame_active = (state == ST_ACTIVE);
  assign spi_miso_oe  = frame_active;
  assign spi_miso     = miso_q;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed bench for spi_byte_slave with an event-queue model of strobes and frame state.
module tb_spi_byte_slave;

  localparam int LAT = 4;  // pin edge to registered response, SYNC_STAGES+2
`ifdef SPI_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, spi_nss, spi_sck, spi_mosi;
  logic       spi_miso, spi_miso_oe, rx_valid, rx_first, tx_load, frame_active, frame_end;
  logic [7:0] rx_data, tx_data, tx_fixed;
  logic       echo_en;

  always #5 clk = ~clk;

  assign tx_data = echo_en ? rx_data + 8'd1 : tx_fixed;

  spi_byte_slave dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_nss      (spi_nss),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_first     (rx_first),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .frame_active (frame_active),
    .frame_end    (frame_end)
  );

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic [7:0] d; logic f; } rx_exp_t;
  typedef struct { int t; logic v; } act_ev_t;
  rx_exp_t rx_q[$];
  act_ev_t act_q[$];
  int      load_q[$];
  int      end_q[$];

  logic       model_act = 1'b0;
  logic [7:0] model_rx  = 8'h00;
  logic       frame_first = 1'b0;
  int         rx_cnt = 0, load_cnt = 0, end_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare of DUT outputs against the event-queue model.
  always @(negedge clk) begin
    logic due_rx, due_ld, due_end;
    while (act_q.size() > 0 && act_q[0].t <= cyc) begin
      model_act = act_q[0].v;
      void'(act_q.pop_front());
    end
    due_rx  = rx_q.size()   > 0 && rx_q[0].t == cyc;
    due_ld  = load_q.size() > 0 && load_q[0]  == cyc;
    due_end = end_q.size()  > 0 && end_q[0]   == cyc;
    if (rx_valid)  rx_cnt++;
    if (tx_load)   load_cnt++;
    if (frame_end) end_cnt++;
    check("rx_valid", rx_valid, due_rx);
    if (due_rx) begin
      model_rx = rx_q[0].d;
      check("rx_first", rx_first, rx_q[0].f);
      void'(rx_q.pop_front());
    end else begin
      check("rx_first", rx_first, 1'b0);
    end
    check("rx_data", rx_data, model_rx);
    check("tx_load", tx_load, due_ld);
    if (due_ld) void'(load_q.pop_front());
    check("frame_end", frame_end, due_end);
    if (due_end) void'(end_q.pop_front());
    check("frame_active", {spi_miso_oe, frame_active}, {model_act, model_act});
  end

  task automatic open_frame();
    spi_nss = 1'b0;
    act_q.push_back('{cyc + LAT, 1'b1});
    load_q.push_back(cyc + LAT);
    frame_first = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic close_frame();
    repeat (4) @(negedge clk);
    spi_nss = 1'b1;
    act_q.push_back('{cyc + LAT, 1'b0});
    end_q.push_back(cyc + LAT);
    repeat (12) @(negedge clk);
  endtask

  // Mode-0 master at clk/8: MOSI changes on SCK fall, both lines sampled on rise.
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] mb, output logic [7:0] seq);
    mb  = 8'h00;
    seq = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = MSB ? 7 - i : i;
      spi_mosi = b[idx];
      repeat (4) @(negedge clk);
      spi_sck  = 1'b1;
      mb[idx]  = spi_miso;
      seq      = {seq[6:0], spi_miso};
      if (i == 7) begin
        rx_q.push_back('{cyc + LAT, b, frame_first});
        load_q.push_back(cyc + LAT);
        frame_first = 1'b0;
      end
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mb, seq, exp1, bo_byte;
    logic [7:0] bytes3 [3];
    int r0, l0, e0;
    bytes3[0] = 8'h41; bytes3[1] = 8'h2A; bytes3[2] = 8'h32;

    reset_n = 1'b0; spi_nss = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b1;
    echo_en = 1'b0; tx_fixed = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      repeat (2) @(negedge clk);
      spi_sck = ~spi_sck;
    end
    check("reset_outputs", {spi_miso, spi_miso_oe, rx_data, rx_valid, rx_first, tx_load,
                            frame_active, frame_end}, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge clk);
      spi_sck = ~spi_sck;
    end
    repeat (10) @(negedge clk);
    check("post_reset_strobes", rx_cnt + load_cnt + end_cnt, 0);
    spi_nss = 1'b1;
    repeat (10) @(negedge clk);

    // Three-byte frame, fixed reply byte
    r0 = rx_cnt; e0 = end_cnt;
    open_frame();
    for (int k = 0; k < 3; k++) begin
      xfer(bytes3[k], 8, mb, seq);
      check("miso_fixed", mb, 8'hA5);
    end
    close_frame();
    check("frame1_rx_count", rx_cnt - r0, 3);
    check("frame1_end_count", end_cnt - e0, 1);
    check("frame1_last_byte", rx_data, 8'h32);

    // Echo: reply = last received byte + 1
    echo_en = 1'b1;
    exp1 = model_rx + 8'd1;
    open_frame();
    xfer(8'h05, 8, mb, seq);
    check("echo_byte1", mb, exp1);
    xfer(8'h10, 8, mb, seq);
    check("echo_byte2", mb, 8'h06);
    close_frame();
    echo_en = 1'b0;
    check("echo_last_byte", rx_data, 8'h10);

    // Abort after 5 bits, then a clean frame
    r0 = rx_cnt; e0 = end_cnt;
    open_frame();
    xfer(8'hFF, 5, mb, seq);
    close_frame();
    check("partial_rx_count", rx_cnt - r0, 0);
    check("partial_end_count", end_cnt - e0, 1);
    open_frame();
    xfer(8'h91, 8, mb, seq);
    close_frame();
    check("after_partial_byte", rx_data, 8'h91);

    // Bit order: wire sequence 1,0,0,1,0,0,0,1 in, 0xC3 out
    tx_fixed = 8'hC3;
    bo_byte  = MSB ? 8'h91 : 8'h89;
    open_frame();
    xfer(bo_byte, 8, mb, seq);
    close_frame();
    check("bitorder_rx", rx_data, MSB ? 32'h91 : 32'h89);
    check("bitorder_miso_seq", seq, 8'hC3);

    // SCK activity with NSS high is ignored
    l0 = load_cnt; r0 = rx_cnt;
    for (int i = 0; i < 16; i++) begin
      repeat (4) @(negedge clk);
      spi_sck = ~spi_sck;
    end
    repeat (10) @(negedge clk);
    check("idle_sck_strobes", (load_cnt - l0) + (rx_cnt - r0), 0);
    check("idle_sck_oe", spi_miso_oe, 1'b0);

    check("pending_events", rx_q.size() + load_q.size() + end_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
